// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes and a maskable IRQ.
// Optional feature: define TIMER_PRESCALER_EN to add a 16-bit prescaler register at offset 0xC.
// Register map (16-byte window at BASE_ADDR):
//   0x0 CTRL   [0] EN, [2:1] MODE (01 auto-reload, otherwise one-shot), [3] IM
//   0x4 PRESET reload value
//   0x8 COUNT  read-only live count
//   0xC PSC    prescaler (only with TIMER_PRESCALER_EN, else reads 0)
module timer_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] CNT  = 2'd2;
  localparam logic [1:0] INT  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic hit, wr_ctrl, wr_preset, wr_psc;
  logic auto_reload;
  logic step;

  assign hit         = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr_ctrl     = we && hit && (addr[3:2] == 2'd0);
  assign wr_preset   = we && hit && (addr[3:2] == 2'd1);
  assign wr_psc      = we && hit && (addr[3:2] == 2'd3);
  assign auto_reload = (ctrl_q[2:1] == 2'b01);

  // Byte-lane bits are irrelevant for word registers.
  logic unused_addr;
  assign unused_addr = ^addr[1:0];

`ifdef TIMER_PRESCALER_EN
  logic [15:0] psc_q, psc_d;
  logic [15:0] pcnt_q, pcnt_d;

  assign step = (pcnt_q == psc_q);
`else
  logic unused_wr_psc;
  assign unused_wr_psc = wr_psc;
  assign step          = 1'b1;
`endif

  // Next-state logic: FSM first, then CPU writes (CTRL write overrides FSM EN-clear).
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
`ifdef TIMER_PRESCALER_EN
    psc_d      = psc_q;
    pcnt_d     = pcnt_q;
`endif

    // A register write acknowledges the pending interrupt; an expiry in the
    // same cycle is a fresh event and sets it again below.
    if (wr_ctrl || wr_preset) begin
      irq_flag_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (ctrl_q[0]) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
`ifdef TIMER_PRESCALER_EN
        pcnt_d  = '0;
`endif
      end
      CNT: begin
        if (!ctrl_q[0]) begin
          state_d = IDLE;
        end else if (step) begin
          if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            count_d    = '0;
            irq_flag_d = 1'b1;
            state_d    = INT;
          end
`ifdef TIMER_PRESCALER_EN
          pcnt_d = '0;
        end else begin
          pcnt_d = pcnt_q + 16'd1;
`endif
        end
      end
      INT: begin
        if (auto_reload) begin
          irq_flag_d = 1'b0;
          state_d    = LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_ctrl) begin
      ctrl_d = wdata[3:0];
    end
    if (wr_preset) begin
      preset_d = wdata;
    end
`ifdef TIMER_PRESCALER_EN
    if (wr_psc) begin
      psc_d = wdata[15:0];
    end
`endif
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
`ifdef TIMER_PRESCALER_EN
      psc_q      <= '0;
      pcnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
`ifdef TIMER_PRESCALER_EN
      psc_q      <= psc_d;
      pcnt_q     <= pcnt_d;
`endif
    end
  end

  // Combinational read mux; misses read zero.
  always_comb begin
    rdata = '0;
    if (hit) begin
      case (addr[3:2])
        2'd0:    rdata = {28'd0, ctrl_q};
        2'd1:    rdata = preset_q;
        2'd2:    rdata = count_q;
`ifdef TIMER_PRESCALER_EN
        default: rdata = {16'd0, psc_q};
`else
        default: rdata = '0;
`endif
      endcase
    end
  end

  assign irq = irq_flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus randomized
// one-shot / auto-reload trials checked against a cycle-count reference model.
module tb_timer_counter;

  localparam logic [31:0] Base = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_assert = 0;
  int n_fail   = 0;

  timer_counter #(.BASE_ADDR(Base)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we    = 1'b0;
    addr  = Base;
    wdata = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    we   = 1'b0;
    #1;
    d = rdata;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    we    = 1'b0;
    addr  = Base;
    wdata = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Reference model: a run of PRESET=n is a period of T = max(n,1)+2 edges after
  // the enabling write (edge 0). Within a period, phase 0/1 show COUNT 0 (INT or
  // pending LOAD), phase p>=2 shows n-(p-2). One-shot stops after the first period.
  task automatic trial(input logic [31:0] n, input logic [1:0] mode, input logic im,
                       input int cycles, input string tag);
    int unsigned t;
    int unsigned p;
    logic        is_auto;
    logic        flag;
    logic [31:0] exp_cnt;
    logic [31:0] rd;
    do_reset();
    bus_write(Base + 32'h4, n);
    bus_write(Base, {28'd0, im, mode, 1'b1});
    t       = ((n == 0) ? 1 : n) + 2;
    is_auto = (mode == 2'b01);
    for (int k = 0; k <= cycles; k++) begin
      if (is_auto) begin
        flag = (k > 0) && ((k % t) == 0);
        p    = k % t;
      end else begin
        flag = (k >= t);
        p    = (k >= t) ? 0 : k;
      end
      exp_cnt = (p < 2) ? 32'd0 : n - (p - 2);
      check($sformatf("%s irq k=%0d", tag, k), {31'd0, irq}, {31'd0, flag & im});
      bus_read(Base + 32'h8, rd);
      check($sformatf("%s count k=%0d", tag, k), rd, exp_cnt);
      tick();
    end
    bus_read(Base, rd);
    check($sformatf("%s ctrl", tag), rd, {28'd0, im, mode, is_auto});
  endtask

  initial begin
    logic [31:0] rd;
    logic        found;
    logic [31:0] rn;
    logic [1:0]  rm;
    logic        ri;

    // 1: reset state
    reset = 1'b0;
    we    = 1'b0;
    addr  = Base;
    wdata = '0;
    do_reset();
    check("rst irq", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus_read(Base + 32'(4 * i), rd);
      check($sformatf("rst reg%0d", i), rd, 32'd0);
    end

    // 2: one-shot PRESET=5, irq rises after E7, held until CTRL write
    trial(32'd5, 2'b00, 1'b1, 9, "t2");
    check("t2 irq held", {31'd0, irq}, 32'd1);
    bus_write(Base, 32'h8);
    check("t2 irq cleared", {31'd0, irq}, 32'd0);

    // 3: auto-reload PRESET=3, 5-cycle period
    trial(32'd3, 2'b01, 1'b1, 16, "t3");

    // 4: IM=0 masks the interrupt
    trial(32'd2, 2'b00, 1'b0, 8, "t4");

    // 5: disable mid-count freezes COUNT, re-enable reloads
    do_reset();
    bus_write(Base + 32'h4, 32'd10);
    bus_write(Base, 32'h9);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      bus_read(Base + 32'h8, rd);
      if (rd == 32'd6) found = 1'b1;
      else tick();
    end
    check("t5 reached 6", {31'd0, found}, 32'd1);
    bus_write(Base, 32'h8);
    for (int i = 0; i < 4; i++) begin
      bus_read(Base + 32'h8, rd);
      check($sformatf("t5 frozen %0d", i), rd, 32'd5);
      check($sformatf("t5 irq %0d", i), {31'd0, irq}, 32'd0);
      tick();
    end
    bus_write(Base, 32'h9);
    tick();
    bus_read(Base + 32'h8, rd);
    check("t5 pre-load", rd, 32'd5);
    tick();
    bus_read(Base + 32'h8, rd);
    check("t5 reload", rd, 32'd10);

    // Reset mid-count aborts with no IRQ
    do_reset();
    check("abort irq", {31'd0, irq}, 32'd0);
    bus_read(Base + 32'h8, rd);
    check("abort count", rd, 32'd0);

    // 6: misses and read-only writes change nothing
    bus_write(Base + 32'h4, 32'h1234);
    bus_write(Base, 32'h8);
    bus_write(Base + 32'h10, 32'hFFFF_FFFF);
    bus_write(Base + 32'h8, 32'hFFFF_FFFF);
    bus_read(Base, rd);
    check("t6 ctrl", rd, 32'h8);
    bus_read(Base + 32'h4, rd);
    check("t6 preset", rd, 32'h1234);
    bus_read(Base + 32'h8, rd);
    check("t6 count", rd, 32'd0);
    bus_read(Base + 32'h10, rd);
    check("t6 miss read", rd, 32'd0);
`ifdef TIMER_PRESCALER_EN
    bus_write(Base + 32'hC, 32'hABCD_0001);
    bus_read(Base + 32'hC, rd);
    check("t6 psc", rd, 32'h1);
    bus_write(Base + 32'h4, 32'd2);
    bus_write(Base, 32'h9);
    for (int k = 0; k <= 8; k++) begin
      check($sformatf("t6 psc irq k=%0d", k), {31'd0, irq}, {31'd0, (k >= 6)});
      tick();
    end
`else
    bus_write(Base + 32'hC, 32'hFFFF_FFFF);
    bus_read(Base + 32'hC, rd);
    check("t6 psc absent", rd, 32'd0);
`endif

    // Randomized trials against the reference model
    for (int r = 0; r < 6; r++) begin
      rn = 32'($urandom_range(0, 7));
      rm = 2'($urandom_range(0, 3));
      ri = 1'($urandom_range(0, 1));
      trial(rn, rm, ri, 3 * (((rn == 0) ? 1 : int'(rn)) + 2) + 2, $sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
